// File: rtl/sram_access_sequencer.sv
// Turns one-shot CPU read/write requests into timed active-low SRAM strobe
// sequences (SETUP, WAIT_CYCLES of ACCESS, HOLD) feeding Mem2IO.
module sram_access_sequencer #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    inout  wire  [DATA_W-1:0] Data
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sram_access_sequencer: WAIT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              data_oe;

    // Bus is driven from SETUP through HOLD of a write so data brackets WE on both sides.
    assign Data = data_oe ? wdata_q : 'z;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            data_oe   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ADDR      <= '0;
            CE        <= 1'b1;
            UB        <= 1'b1;
            LB        <= 1'b1;
            OE        <= 1'b1;
            WE        <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        state     <= S_SETUP;
                        req_ready <= 1'b0;
                        ADDR      <= req_addr;
                        we_q      <= req_we;
                        wdata_q   <= req_wdata;
                        CE        <= 1'b0;
                        if (req_we) begin
                            UB      <= ~req_be[1];
                            LB      <= ~req_be[0];
                            data_oe <= 1'b1;
                        end else begin
                            UB <= 1'b0;
                            LB <= 1'b0;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_ACCESS;
                    cnt   <= CNT_W'(WAIT_CYCLES - 1);
                    if (we_q) begin
                        WE <= 1'b0;
                    end else begin
                        OE <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        state     <= S_HOLD;
                        OE        <= 1'b1;
                        WE        <= 1'b1;
                        rsp_valid <= 1'b1;
                        // OE is still low during this cycle, so the SRAM is driving the bus.
                        if (!we_q) begin
                            rsp_rdata <= Data;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    CE        <= 1'b1;
                    UB        <= 1'b1;
                    LB        <= 1'b1;
                    data_oe   <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
